ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter_pkg.sv | 34 +++
 rtl/ahb_arbiter_rr_pick.sv | 34 +++
 rtl/ahb_arbiter.sv | 100 ++++++++++
 tb/tb_ahb_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB definitions for the bus arbiter: the HTrans encodings and their
// width, the arbiter FSM state type, and a one-hot to index helper.
// No ports (package).

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif

package ahb_arbiter_pkg;

   typedef enum logic [`AHB_TRANS_BITS-1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_LOCKED
   } arb_state_t;

   // Up to four masters; callers zero-extend narrower grant vectors.
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Round-robin priority pick.
//   req   : request vector, one bit per master
//   ptr   : index of the last winner (lowest priority this round)
//   grant : one-hot winner, all-zero when nobody requests

module rr_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant
);

   localparam int IW = $clog2(N);

   logic          found;
   logic [IW-1:0] idx;

   // Search starts one past the last winner and wraps, so the last winner
   // is examined last.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with lock and burst hold.
//   clk         : single clock, rising edge
//   rst         : asynchronous, active-low reset
//   HReq        : bus request per master
//   HLock       : locked-transfer request per master
//   HTrans      : transfer type of the current address-phase owner
//   HReady      : slave ready; all arbiter state advances only when high
//   HGrant      : registered one-hot grant
//   HMaster     : address-phase owner index
//   HMasterData : data-phase owner index (read/write data mux select)
//   HMastLock   : current address phase is locked
//
// state      | meaning
// ARB_IDLE   | nobody requested, default master parked on the bus
// ARB_GRANT  | unlocked owner holds the grant
// ARB_LOCKED | owner holds HLock, re-arbitration frozen

module ahb_arbiter
   import ahb_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_MASTERS-1:0]         HReq,
   input  logic [NUM_MASTERS-1:0]         HLock,
   input  logic [`AHB_TRANS_BITS-1:0]     HTrans,
   input  logic                           HReady,
   output logic [NUM_MASTERS-1:0]         HGrant,
   output logic [$clog2(NUM_MASTERS)-1:0] HMaster,
   output logic [$clog2(NUM_MASTERS)-1:0] HMasterData,
   output logic                           HMastLock
);

   localparam int                     IW        = $clog2(NUM_MASTERS);
   localparam logic [IW-1:0]          DEF_IDX   = IW'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_d;
   logic [NUM_MASTERS-1:0] pick;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          grant_idx;
   logic [IW-1:0]          pick_idx;
   logic                   owner_lock;
   logic                   blocked;

   rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
      .req   (HReq),
      .ptr   (ptr_q),
      .grant (pick)
   );

   assign grant_idx  = IW'(onehot_to_idx(4'(HGrant)));
   assign pick_idx   = IW'(onehot_to_idx(4'(pick)));
   assign owner_lock = HLock[grant_idx];
   // A burst in progress (BUSY/SEQ) must not be split across owners.
   assign blocked    = owner_lock || (HTrans == TRANS_BUSY) || (HTrans == TRANS_SEQ);

   always_comb begin
      state_d = state_q;
      grant_d = HGrant;
      ptr_d   = ptr_q;
      if (blocked) begin
         if (owner_lock) begin
            state_d = ARB_LOCKED;
         end else if (state_q == ARB_LOCKED) begin
            state_d = ARB_GRANT;
         end
      end else if (|HReq) begin
         grant_d = pick;
         ptr_d   = pick_idx;
         state_d = ARB_GRANT;
      end else begin
         // Park on the default master; the round-robin pointer keeps its place.
         grant_d = DEF_GRANT;
         state_d = ARB_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         HGrant      <= DEF_GRANT;
         HMaster     <= DEF_IDX;
         HMasterData <= DEF_IDX;
         HMastLock   <= 1'b0;
         state_q     <= ARB_IDLE;
         ptr_q       <= DEF_IDX;
      end else if (HReady) begin
         HMasterData <= HMaster;
         HMaster     <= grant_idx;
         HMastLock   <= owner_lock;
         HGrant      <= grant_d;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;
   import ahb_arbiter_pkg::*;

   logic       clk;
   logic       rst;
   logic [1:0] HReq;
   logic [1:0] HLock;
   logic [1:0] HTrans;
   logic       HReady;
   logic [1:0] HGrant;
   logic       HMaster;
   logic       HMasterData;
   logic       HMastLock;

   ahb_arbiter #(.NUM_MASTERS(2), .DEFAULT_MASTER(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .HReq        (HReq),
      .HLock       (HLock),
      .HTrans      (HTrans),
      .HReady      (HReady),
      .HGrant      (HGrant),
      .HMaster     (HMaster),
      .HMasterData (HMasterData),
      .HMastLock   (HMastLock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [1:0] lock;
      logic [1:0] trans;
      logic       ready;
      logic [1:0] g;
      logic       m;
      logic       d;
      logic       l;
      arb_state_t st;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] trans,
                      input logic ready, input logic [1:0] g, input logic m, input logic d,
                      input logic l, input arb_state_t st);
      vec_t v;
      v.req = req; v.lock = lock; v.trans = trans; v.ready = ready;
      v.g = g; v.m = m; v.d = d; v.l = l; v.st = st;
      vecs.push_back(v);
   endtask

   // Caller is at a negedge; drives, waits for the edge, scores, ends at the next negedge.
   task automatic apply(input int i, input vec_t v);
      vec_t e;
      HReq   = v.req;
      HLock  = v.lock;
      HTrans = v.trans;
      HReady = v.ready;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL v%0d scoreboard empty", i);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("v%0d HGrant", i), 32'(HGrant), 32'(e.g));
         check($sformatf("v%0d HMaster", i), 32'(HMaster), 32'(e.m));
         check($sformatf("v%0d HMasterData", i), 32'(HMasterData), 32'(e.d));
         check($sformatf("v%0d HMastLock", i), 32'(HMastLock), 32'(e.l));
         check($sformatf("v%0d state", i), 32'(dut.state_q), 32'(e.st));
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      localparam logic [1:0] NS = 2'b10;
      localparam logic [1:0] SQ = 2'b11;
      localparam logic [1:0] BS = 2'b01;
      localparam logic [1:0] ID = 2'b00;

      // round robin with both requesting
      add(2'b11, 2'b00, NS, 1, 2'b10, 0, 0, 0, ARB_GRANT);
      add(2'b11, 2'b00, NS, 1, 2'b01, 1, 0, 0, ARB_GRANT);
      add(2'b11, 2'b00, NS, 1, 2'b10, 0, 1, 0, ARB_GRANT);
      add(2'b11, 2'b00, NS, 1, 2'b01, 1, 0, 0, ARB_GRANT);
      // wait states: everything frozen while requests move
      add(2'b10, 2'b00, NS, 0, 2'b01, 1, 0, 0, ARB_GRANT);
      add(2'b01, 2'b00, NS, 0, 2'b01, 1, 0, 0, ARB_GRANT);
      add(2'b00, 2'b00, NS, 0, 2'b01, 1, 0, 0, ARB_GRANT);
      add(2'b10, 2'b00, NS, 1, 2'b10, 0, 1, 0, ARB_GRANT);
      // master 1 locked while master 0 competes
      add(2'b11, 2'b10, NS, 1, 2'b10, 1, 0, 1, ARB_LOCKED);
      add(2'b11, 2'b10, NS, 1, 2'b10, 1, 1, 1, ARB_LOCKED);
      add(2'b11, 2'b10, NS, 1, 2'b10, 1, 1, 1, ARB_LOCKED);
      add(2'b11, 2'b10, NS, 1, 2'b10, 1, 1, 1, ARB_LOCKED);
      add(2'b11, 2'b00, NS, 1, 2'b01, 1, 1, 0, ARB_GRANT);
      // burst hold on SEQ, then BUSY
      add(2'b11, 2'b00, SQ, 1, 2'b01, 0, 1, 0, ARB_GRANT);
      add(2'b11, 2'b00, SQ, 1, 2'b01, 0, 0, 0, ARB_GRANT);
      add(2'b11, 2'b00, SQ, 1, 2'b01, 0, 0, 0, ARB_GRANT);
      add(2'b11, 2'b00, NS, 1, 2'b10, 0, 0, 0, ARB_GRANT);
      add(2'b11, 2'b00, BS, 1, 2'b10, 1, 0, 0, ARB_GRANT);
      add(2'b11, 2'b00, ID, 1, 2'b01, 1, 1, 0, ARB_GRANT);
      // single requester keeps the grant
      add(2'b10, 2'b00, NS, 1, 2'b10, 0, 1, 0, ARB_GRANT);
      add(2'b10, 2'b00, NS, 1, 2'b10, 1, 0, 0, ARB_GRANT);
      // idle parks on default; pointer stays on master 1
      add(2'b00, 2'b00, ID, 1, 2'b01, 1, 1, 0, ARB_IDLE);
      add(2'b00, 2'b00, ID, 1, 2'b01, 0, 1, 0, ARB_IDLE);
      add(2'b11, 2'b00, NS, 1, 2'b01, 0, 0, 0, ARB_GRANT);
      add(2'b00, 2'b00, ID, 1, 2'b01, 0, 0, 0, ARB_IDLE);
      add(2'b10, 2'b00, NS, 1, 2'b10, 0, 0, 0, ARB_GRANT);
      // owner drops its request
      add(2'b01, 2'b00, NS, 1, 2'b01, 1, 0, 0, ARB_GRANT);
      add(2'b10, 2'b00, NS, 1, 2'b10, 0, 1, 0, ARB_GRANT);
      add(2'b10, 2'b10, NS, 1, 2'b10, 1, 0, 1, ARB_LOCKED);

      // reset held with both masters requesting
      rst    = 1'b0;
      HReq   = 2'b11;
      HLock  = 2'b00;
      HTrans = NS;
      HReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset HGrant", 32'(HGrant), 32'h1);
      check("reset HMaster", 32'(HMaster), 32'h0);
      check("reset HMasterData", 32'(HMasterData), 32'h0);
      check("reset HMastLock", 32'(HMastLock), 32'h0);
      check("reset state", 32'(dut.state_q), 32'(ARB_IDLE));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(i, vecs[i]);
      end

      // reset mid-transfer with HReady low must act without a clock edge
      HReady = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("abort HGrant", 32'(HGrant), 32'h1);
      check("abort HMaster", 32'(HMaster), 32'h0);
      check("abort HMasterData", 32'(HMasterData), 32'h0);
      check("abort HMastLock", 32'(HMastLock), 32'h0);
      check("abort state", 32'(dut.state_q), 32'(ARB_IDLE));

      @(negedge clk);
      rst    = 1'b1;
      HReady = 1'b1;
      HReq   = 2'b11;
      HLock  = 2'b00;
      HTrans = NS;
      @(posedge clk);
      #1;
      check("resume HGrant", 32'(HGrant), 32'h2);
      check("resume HMaster", 32'(HMaster), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
